// File: rtl/mux_share_arbiter_if.sv
// mux_share_arbiter_if: requester-side signals and shared output channel of the 2:1 arbiter
interface mux_share_arbiter_if #(parameter int W = 8);
   logic         req0, req1;
   logic [W-1:0] d0, d1;
   logic         gnt0, gnt1, sel, y_valid;
   logic [W-1:0] y;
   modport master (output req0, req1, d0, d1, input gnt0, gnt1, sel, y, y_valid);
   modport slave  (input req0, req1, d0, d1, output gnt0, gnt1, sel, y, y_valid);
endinterface

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: two-requester round-robin arbiter time-sharing one 2:1 data mux
module mux_share_arbiter #(
   parameter int W        = 8,
   parameter int MAX_HOLD = 4
) (
   input logic                clk,
   input logic                rst_n,
   mux_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
   state_t       state_q, state_d;
   logic         sel_q, sel_d, last_q, last_d;
   logic [7:0]   hold_q, hold_d;
   logic         sat;
   logic [W-1:0] y_mux;
   assign sat = hold_q == 8'(MAX_HOLD - 1);
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE:    state_d = (bus.req0 && (!bus.req1 || last_q)) ? GRANT0 : bus.req1 ? GRANT1 : IDLE;
         GRANT0:  state_d = (!bus.req0 || (bus.req1 && sat)) ? (bus.req1 ? GRANT1 : IDLE) : GRANT0;
         GRANT1:  state_d = (!bus.req1 || (bus.req0 && sat)) ? (bus.req0 ? GRANT0 : IDLE) : GRANT1;
         default: state_d = IDLE;
      endcase
      // entering a grant restarts the hold window; keeping it counts up to saturation
      if (state_d != IDLE && state_d != state_q) begin
         hold_d = '0;
         sel_d  = state_d == GRANT1;
         last_d = state_d == GRANT1;
      end else if (state_d != IDLE) begin
         hold_d = sat ? hold_q : hold_q + 8'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         last_q  <= 1'b1;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end
   assign y_mux       = sel_q ? bus.d1 : bus.d0;
   assign bus.y       = y_mux;
   assign bus.gnt0    = state_q == GRANT0;
   assign bus.gnt1    = state_q == GRANT1;
   assign bus.sel     = sel_q;
   assign bus.y_valid = (state_q == GRANT0 && bus.req0) || (state_q == GRANT1 && bus.req1);
endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: random and directed stimulus scored against an ownership-level model
module tb_mux_share_arbiter;
   localparam int W  = 8;
   localparam int MH = 4;
   typedef struct {
      logic         g0, g1, s, v;
      logic [W-1:0] y;
   } exp_t;
   logic clk = 0;
   logic rst_n = 0;
   logic active = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   int   owner = -1;
   int   run = 0;
   int   last_m = 1;
   logic sel_m = 0;
   mux_share_arbiter_if #(.W(W)) bus();
   mux_share_arbiter #(.W(W), .MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;
   function automatic void model_step(input logic r0, input logic r1, input logic rn);
      int nxt;
      logic req[2];
      if (!rn) begin
         owner = -1; run = 0; last_m = 1; sel_m = 0;
         return;
      end
      req[0] = r0; req[1] = r1;
      if (owner < 0)
         nxt = (r0 && r1) ? 1 - last_m : r0 ? 0 : r1 ? 1 : -1;
      else if (!req[owner])
         nxt = req[1 - owner] ? 1 - owner : -1;
      else if (req[1 - owner] && run >= MH)
         nxt = 1 - owner;
      else
         nxt = owner;
      if (nxt >= 0 && nxt != owner) begin
         run = 1; last_m = nxt; sel_m = nxt[0];
      end else if (nxt >= 0) begin
         run++;
      end
      owner = nxt;
   endfunction
   task automatic cycle(input logic r0, input logic r1, input logic rn, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      @(posedge clk);
      #2;
      model_step(bus.req0, bus.req1, rst_n);
      rst_n = rn; bus.req0 = r0; bus.req1 = r1; bus.d0 = a; bus.d1 = b;
      e.g0 = owner == 0;
      e.g1 = owner == 1;
      e.s  = sel_m;
      e.v  = (owner == 0 && r0) || (owner == 1 && r1);
      e.y  = sel_m ? b : a;
      sb.push_back(e);
      active = 1;
   endtask
   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask
   always @(negedge clk) begin
      if (active) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty at %0t", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("gnt0", W'(bus.gnt0), W'(e.g0));
            chk("gnt1", W'(bus.gnt1), W'(e.g1));
            chk("sel", W'(bus.sel), W'(e.s));
            chk("y_valid", W'(bus.y_valid), W'(e.v));
            chk("y", bus.y, e.y);
         end
      end
   end
   initial begin
      bus.req0 = 1; bus.req1 = 1; bus.d0 = 8'h11; bus.d1 = 8'h22;
      // reset held with both requesting, then release: requester 0 wins first
      cycle(1, 1, 0, 8'h11, 8'h22);
      cycle(1, 1, 1, 8'h11, 8'h22);
      for (int i = 0; i < 3; i++) cycle(1, 1, 1, 8'h33, 8'h44);
      cycle(0, 0, 1, 8'h00, 8'h00);
      cycle(0, 0, 1, 8'h00, 8'h00);
      // lone requester 1 never preempted
      for (int i = 0; i < 11; i++) cycle(0, 1, 1, 8'h5A, 8'hA5);
      cycle(0, 0, 1, 8'h00, 8'h00);
      cycle(0, 0, 1, 8'h00, 8'h00);
      // sustained contention rotates every MH cycles
      for (int i = 0; i < 20; i++) cycle(1, 1, 1, 8'(i), 8'(8'h80 + i));
      cycle(0, 0, 1, 8'h00, 8'h00);
      cycle(0, 0, 1, 8'h00, 8'h00);
      // handoff 0 -> 1 without idle, then drop to idle
      cycle(1, 0, 1, 8'hC0, 8'hC1);
      cycle(1, 0, 1, 8'hC0, 8'hC1);
      cycle(0, 1, 1, 8'hC2, 8'hC3);
      cycle(0, 1, 1, 8'hC2, 8'hC3);
      cycle(0, 0, 1, 8'hC4, 8'hC5);
      cycle(0, 0, 1, 8'hC4, 8'hC5);
      // tie from idle after requester 1 and after requester 0
      cycle(1, 1, 1, 8'hD0, 8'hD1);
      cycle(0, 0, 1, 8'hD0, 8'hD1);
      cycle(0, 0, 1, 8'hD0, 8'hD1);
      cycle(1, 1, 1, 8'hD2, 8'hD3);
      cycle(0, 0, 1, 8'hD2, 8'hD3);
      // reset mid-grant of requester 1
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 8'hE0, 8'hE1);
      cycle(1, 1, 0, 8'hE2, 8'hE3);
      for (int i = 0; i < 3; i++) cycle(1, 1, 1, 8'hE4, 8'hE5);
      // saturated hold then a late competing request
      for (int i = 0; i < 8; i++) cycle(1, 0, 1, 8'hF0, 8'hF1);
      for (int i = 0; i < 3; i++) cycle(1, 1, 1, 8'hF2, 8'hF3);
      for (int i = 0; i < 600; i++) begin
         int k;
         k = int'($urandom_range(0, 99));
         cycle(k < 70 ? $urandom_range(0, 3) != 0 : 1'b0,
               k < 40 || k >= 70 ? $urandom_range(0, 3) != 0 : 1'b0,
               $urandom_range(0, 49) != 0, 8'($urandom), 8'($urandom));
      end
      @(negedge clk);
      #1;
      active = 0;
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
- Two-requester round-robin arbiter that time-shares one 2:1 data mux onto a single output channel.
- Each requester presents a request and a W-bit data word. The arbiter registers a grant, drives the mux select, and forwards the granted word with a valid flag.
- Sits in front of any shared single-consumer resource in the lab datapath, such as a display driver or result register.

Parameters:
- W, 8, data width of each requester word and of the output word.
- MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant while the other is requesting. Legal range 1..255.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req0  input  1  requester 0 wants the channel; held high for as long as it has data.
- req1  input  1  requester 1 wants the channel.
- d0  input  W  requester 0 data word.
- d1  input  W  requester 1 data word.
- gnt0  output  1  requester 0 owns the channel this cycle (registered).
- gnt1  output  1  requester 1 owns the channel this cycle (registered).
- sel  output  1  mux select: 0 selects d0, 1 selects d1 (registered).
- y  output  W  output word = sel ? d1 : d0 (combinational from registered sel).
- y_valid  output  1  (gnt0 & req0) | (gnt1 & req1).

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; gnt0=0; gnt1=0; sel=0; hold_cnt=0; last=1, so requester 0 wins the first tie.
  - y_valid=0; y=d0.
  - Reset mid-grant drops the grant on that same edge, with no completion cycle.
- States: IDLE, GRANT0, GRANT1. gnt0=(state==GRANT0), gnt1=(state==GRANT1). gntX is never 1 for both.
- Latency: a req sampled high at edge N gives a grant visible after edge N, i.e. one cycle, when the channel is free.
- sel changes only on entry to GRANTx. In IDLE, sel holds the last granted index.
- IDLE transitions:
  - Only req0 → GRANT0.
  - Only req1 → GRANT1.
  - Both → GRANT of !last.
  - Neither → stay in IDLE.
- GRANTx transitions (y is the other requester):
  - reqx low and reqy high → GRANTy directly, with no idle gap.
  - reqx low and reqy low → IDLE.
  - reqx high, reqy high and hold_cnt==MAX_HOLD-1 → GRANTy (preemption).
  - Otherwise → stay in GRANTx.
- hold_cnt:
  - Cleared to 0 on every entry to GRANTx.
  - Increments each cycle the grant is kept.
  - Saturates at MAX_HOLD-1 while the other requester is idle, so the grant persists indefinitely.
  - Once saturated, a later reqy assertion causes a switch on the next edge.
- last: updated to x on every entry to GRANTx; unchanged in IDLE.
- MAX_HOLD=1: both requesting gives strict alternation every cycle.
- Simultaneous events:
  - reqx drop together with reqy rise → GRANTy.
  - Both requests drop → IDLE.
  - rst_n low overrides all.
- y_valid is low during any cycle in which the granted requester has dropped req but the state has not yet updated.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req0=req1=1 → gnt0=gnt1=0, sel=0, y_valid=0. Release rst_n → gnt0=1 one cycle later, sel=0.
- Single requester: req1=1 only, d1=8'hA5 for 10 cycles → gnt1=1 from cycle 1 to 10, sel=1, y=8'hA5, y_valid=1; no preemption.
- Contention with MAX_HOLD=4: req0=req1=1 continuously → grant pattern 0,0,0,0,1,1,1,1,0,... with sel tracking and no cycle where both gnt are high.
- Handoff: GRANT0 active, req0 drops while req1=1 → next cycle gnt1=1, sel=1, no IDLE cycle. Then req1 drops → IDLE, sel stays 1.
- Tie-break after IDLE: last grant was requester 0, both assert together from IDLE → gnt1 wins.
- Reset mid-grant: at hold_cnt=2 in GRANT1, pulse rst_n low for 1 cycle → gnt1=0, sel=0. Then with req0=req1=1, requester 0 is granted first.
